// File: rtl/idma_desc64_mc_queue.sv
// idma_desc64_mc_queue
// Multi-channel descriptor submission queue. Descriptor addresses are pushed
// per channel into small FIFOs, round-robin arbitrated onto one fetch port
// under a global outstanding limit, and completions raise per-channel pending
// interrupt flags.
//
// Ports:
//   clk_i, rst_i                  clock, async active-high reset
//   submit_valid_i/ready_o        submit handshake; chan_i/addr_i payload
//   desc_valid_o/ready_i          fetch handshake; addr_o/chan_o payload
//   done_valid_i, done_chan_i     completion pulse and its channel
//   irq_mask_i, irq_clear_i       per-channel mask and pending clear
//   pending_o, busy_o, irq_o      per-channel status and merged interrupt
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | no offer held; desc_* follows the live arbitration result
// ST_HOLD | offer stalled by fetch unit; channel locked until accepted
module idma_desc64_mc_queue #(
  parameter int NumChannels    = 4,
  parameter int AddrWidth      = 64,
  parameter int FifoDepth      = 4,
  parameter int MaxOutstanding = 8,
  localparam int ChanW = (NumChannels > 1) ? $clog2(NumChannels) : 1,
  localparam int OutW  = $clog2(MaxOutstanding + 1)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   submit_valid_i,
  output logic                   submit_ready_o,
  input  logic [ChanW-1:0]       submit_chan_i,
  input  logic [AddrWidth-1:0]   submit_addr_i,
  output logic                   desc_valid_o,
  input  logic                   desc_ready_i,
  output logic [AddrWidth-1:0]   desc_addr_o,
  output logic [ChanW-1:0]       desc_chan_o,
  input  logic                   done_valid_i,
  input  logic [ChanW-1:0]       done_chan_i,
  input  logic [NumChannels-1:0] irq_mask_i,
  input  logic [NumChannels-1:0] irq_clear_i,
  output logic [NumChannels-1:0] pending_o,
  output logic [NumChannels-1:0] busy_o,
  output logic                   irq_o
);

  localparam int PtrW = $clog2(FifoDepth);
  localparam int CntW = PtrW + 1;

  typedef enum logic {ST_IDLE, ST_HOLD} state_e;

  state_e                           state_q, state_d;
  logic [ChanW-1:0]                 lock_chan_q, lock_chan_d;
  logic [ChanW-1:0]                 rr_ptr_q, rr_ptr_d;
  logic [NumChannels-1:0][PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [NumChannels-1:0][PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [NumChannels-1:0][CntW-1:0] cnt_q, cnt_d;
  logic [NumChannels-1:0][OutW-1:0] chan_out_q, chan_out_d;
  logic [OutW-1:0]                  glob_out_q, glob_out_d;
  logic [NumChannels-1:0]           pending_q, pending_d;
  logic [AddrWidth-1:0]             mem_q [NumChannels][FifoDepth];

  logic [NumChannels-1:0] fifo_empty, fifo_full, push, pop, done_hit;
  logic                   arb_found, offer_ok, desc_valid, desc_hs;
  logic [ChanW-1:0]       arb_chan, grant_chan, cand;

  // Round-robin search starting one past the last granted channel.
  always_comb begin
    arb_found = 1'b0;
    arb_chan  = '0;
    cand      = '0;
    for (int i = 1; i <= NumChannels; i++) begin
      cand = ChanW'((int'(rr_ptr_q) + i) % NumChannels);
      if (!arb_found && !fifo_empty[cand]) begin
        arb_found = 1'b1;
        arb_chan  = cand;
      end
    end
  end

  always_comb begin
    for (int c = 0; c < NumChannels; c++) begin
      fifo_empty[c] = (cnt_q[c] == '0);
      fifo_full[c]  = (cnt_q[c] == CntW'(FifoDepth));
    end
    offer_ok   = (glob_out_q < OutW'(MaxOutstanding));
    // A held offer never re-checks the limit: outstanding can only have
    // dropped since the offer was raised.
    desc_valid = (state_q == ST_HOLD) || (arb_found && offer_ok);
    grant_chan = (state_q == ST_HOLD) ? lock_chan_q : arb_chan;
    desc_hs    = desc_valid && desc_ready_i;

    // Out-of-range channels match no FIFO, so they are never ready.
    submit_ready_o = 1'b0;
    for (int c = 0; c < NumChannels; c++) begin
      if (submit_chan_i == ChanW'(c)) submit_ready_o = !fifo_full[c];
      push[c]     = submit_valid_i && (submit_chan_i == ChanW'(c)) && !fifo_full[c];
      pop[c]      = desc_hs && (grant_chan == ChanW'(c));
      done_hit[c] = done_valid_i && (done_chan_i == ChanW'(c)) && (chan_out_q[c] != '0);
    end

    for (int c = 0; c < NumChannels; c++) begin
      wr_ptr_d[c]   = wr_ptr_q[c] + PtrW'(push[c]);
      rd_ptr_d[c]   = rd_ptr_q[c] + PtrW'(pop[c]);
      cnt_d[c]      = cnt_q[c] + CntW'(push[c]) - CntW'(pop[c]);
      chan_out_d[c] = chan_out_q[c] + OutW'(pop[c]) - OutW'(done_hit[c]);
      pending_d[c]  = (pending_q[c] & ~irq_clear_i[c]) | done_hit[c];
    end
    glob_out_d = glob_out_q + OutW'(desc_hs) - OutW'(|done_hit);

    state_d     = state_q;
    lock_chan_d = lock_chan_q;
    rr_ptr_d    = rr_ptr_q;
    if (desc_hs) begin
      state_d  = ST_IDLE;
      rr_ptr_d = grant_chan;
    end else if (desc_valid) begin
      state_d     = ST_HOLD;
      lock_chan_d = grant_chan;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      lock_chan_q <= '0;
      rr_ptr_q    <= ChanW'(NumChannels - 1);
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      chan_out_q  <= '0;
      glob_out_q  <= '0;
      pending_q   <= '0;
    end else begin
      state_q     <= state_d;
      lock_chan_q <= lock_chan_d;
      rr_ptr_q    <= rr_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      chan_out_q  <= chan_out_d;
      glob_out_q  <= glob_out_d;
      pending_q   <= pending_d;
    end
  end

  // Storage needs no reset: occupancy counters gate every read.
  always_ff @(posedge clk_i) begin
    for (int c = 0; c < NumChannels; c++) begin
      if (push[c]) mem_q[c][wr_ptr_q[c]] <= submit_addr_i;
    end
  end

  always_comb begin
    desc_valid_o = desc_valid;
    desc_chan_o  = desc_valid ? grant_chan : '0;
    desc_addr_o  = desc_valid ? mem_q[grant_chan][rd_ptr_q[grant_chan]] : '0;
    pending_o    = pending_q;
    for (int c = 0; c < NumChannels; c++) begin
      busy_o[c] = !fifo_empty[c] || (chan_out_q[c] != '0);
    end
    irq_o = |(pending_q & ~irq_mask_i);
  end

endmodule
